// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl_if
//  Brief    : Decode/execute control, instruction-memory and Fetch->Decode
//             signals of the fetch sequencer, grouped with directional modports.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_ctrl_if;
    logic        stall_d_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        en_f_o;
    logic [31:0] pc_f_o;
    logic [31:0] instr_f_o;
    logic        flush_d_o;
    logic [31:0] fetch_cnt_o;

    modport master (
        input  stall_d_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, en_f_o, pc_f_o, instr_f_o, flush_d_o,
               fetch_cnt_o
    );

    modport slave (
        output stall_d_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, en_f_o, pc_f_o, instr_f_o, flush_d_o,
               fetch_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Brief    : Fetch-stage sequencer: PC, imem handshake, one-entry stall hold
//             buffer and redirect/flush handling.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    fetch_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_cnt;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_tgt_nxt;
    logic [31:0] w_target;
    logic        w_hold_ld;
    logic        w_req;
    logic        w_en;
    logic        w_flush;
    logic [31:0] w_pc_f;
    logic [31:0] w_instr_f;

    assign w_target = {bus.redirect_pc_i[31:2], 2'b00};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_tgt        <= RESET_PC;
            r_hold_pc    <= 32'd0;
            r_hold_instr <= 32'd0;
            r_cnt        <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;
            if (w_hold_ld) begin
                r_hold_pc    <= r_pc;
                r_hold_instr <= bus.imem_rdata_i;
            end
            if (w_en) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    // Redirect is decoded first in every state so it overrides stall and ack.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt;
        w_hold_ld   = 1'b0;
        w_req       = 1'b0;
        w_en        = 1'b0;
        w_flush     = 1'b0;
        w_pc_f      = 32'd0;
        w_instr_f   = 32'd0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_REQ;
                if (bus.redirect_i) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = w_target;
                end
            end
            ST_REQ: begin
                w_req     = 1'b1;
                w_pc_f    = r_pc;
                w_instr_f = bus.imem_rdata_i;
                if (bus.redirect_i) begin
                    w_flush = 1'b1;
                    if (bus.imem_ack_i) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_tgt_nxt   = w_target;
                        w_state_nxt = ST_DRAIN;
                    end
                end else if (bus.imem_ack_i) begin
                    w_pc_nxt = r_pc + 32'd4;
                    if (bus.stall_d_i) begin
                        w_hold_ld   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_en = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                w_pc_f    = r_hold_pc;
                w_instr_f = r_hold_instr;
                if (bus.redirect_i) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_REQ;
                end else if (!bus.stall_d_i) begin
                    w_en        = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // The stale request must complete before the target is fetched.
                w_req = 1'b1;
                if (bus.redirect_i) begin
                    w_flush = 1'b1;
                    if (bus.imem_ack_i) begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_tgt_nxt = w_target;
                    end
                end else if (bus.imem_ack_i) begin
                    w_pc_nxt    = r_tgt;
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign bus.imem_req_o  = w_req;
    assign bus.imem_addr_o = r_pc;
    assign bus.en_f_o      = w_en;
    assign bus.pc_f_o      = w_pc_f;
    assign bus.instr_f_o   = w_instr_f;
    assign bus.flush_d_o   = w_flush;
    assign bus.fetch_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_ctrl
//  Brief    : Directed testbench for fetch_ctrl; memory returns ~address.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fetch_ctrl_if bif ();
    fetch_ctrl_if bif2 ();

    assign bif.imem_rdata_i  = ~bif.imem_addr_o;
    assign bif2.imem_rdata_i = ~bif2.imem_addr_o;

    fetch_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif.master)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk_i (clk),
        .rst_i (rst2),
        .bus   (bif2.master)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic stall, input logic redir, input logic [31:0] rpc);
        bif.imem_ack_i    = ack;
        bif.stall_d_i     = stall;
        bif.redirect_i    = redir;
        bif.redirect_pc_i = rpc;
    endtask

    task automatic do_reset;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        #2;
        n_vec++;
        if ({bif.imem_req_o, bif.en_f_o, bif.flush_d_o, bif.imem_addr_o, bif.pc_f_o, bif.instr_f_o, bif.fetch_cnt_o}
            !== {3'b000, 32'd0, 32'd0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_outputs: got req=%b en=%b fl=%b addr=%h pc=%h ins=%h cnt=%0d, want all 0",
                     bif.imem_req_o, bif.en_f_o, bif.flush_d_o, bif.imem_addr_o, bif.pc_f_o, bif.instr_f_o, bif.fetch_cnt_o);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bif.imem_req_o, bif.en_f_o} !== 2'b00) begin
            n_err++;
            $display("FAIL boot_no_req: got req=%b en=%b, want 0 0", bif.imem_req_o, bif.en_f_o);
        end
        tick();
    endtask

    task automatic test_sequential;
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if ({bif.imem_req_o, bif.en_f_o, bif.imem_addr_o, bif.pc_f_o, bif.instr_f_o}
                !== {2'b11, 32'(4*i), 32'(4*i), ~32'(4*i)}) begin
                n_err++;
                $display("FAIL seq_fetch[%0d]: got req=%b en=%b addr=%h pc=%h ins=%h, want 1 1 %h",
                         i, bif.imem_req_o, bif.en_f_o, bif.imem_addr_o, bif.pc_f_o, bif.instr_f_o, 32'(4*i));
            end
            tick();
        end
        n_vec++;
        if (bif.fetch_cnt_o !== 32'd5) begin
            n_err++;
            $display("FAIL seq_count: got %0d, want 5", bif.fetch_cnt_o);
        end
    endtask

    task automatic test_stall;
        do_reset();
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        n_vec++;
        if ({bif.imem_req_o, bif.en_f_o, bif.imem_addr_o} !== {2'b10, 32'd8}) begin
            n_err++;
            $display("FAIL stall_ack: got req=%b en=%b addr=%h, want 1 0 8", bif.imem_req_o, bif.en_f_o, bif.imem_addr_o);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if ({bif.imem_req_o, bif.en_f_o, bif.pc_f_o, bif.instr_f_o} !== {2'b00, 32'd8, ~32'd8}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got req=%b en=%b pc=%h ins=%h, want 0 0 8 %h",
                         i, bif.imem_req_o, bif.en_f_o, bif.pc_f_o, bif.instr_f_o, ~32'd8);
            end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        n_vec++;
        if ({bif.imem_req_o, bif.en_f_o, bif.pc_f_o, bif.instr_f_o} !== {2'b01, 32'd8, ~32'd8}) begin
            n_err++;
            $display("FAIL stall_release: got req=%b en=%b pc=%h ins=%h, want 0 1 8", bif.imem_req_o, bif.en_f_o, bif.pc_f_o, bif.instr_f_o);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({bif.imem_req_o, bif.en_f_o, bif.imem_addr_o, bif.fetch_cnt_o} !== {2'b11, 32'd12, 32'd3}) begin
            n_err++;
            $display("FAIL stall_next: got req=%b en=%b addr=%h cnt=%0d, want 1 1 c 3",
                     bif.imem_req_o, bif.en_f_o, bif.imem_addr_o, bif.fetch_cnt_o);
        end
        tick();
    endtask

    task automatic test_redirect_drain;
        do_reset();
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (4) tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        @(negedge clk);
        n_vec++;
        if ({bif.flush_d_o, bif.en_f_o, bif.imem_addr_o} !== {2'b10, 32'd16}) begin
            n_err++;
            $display("FAIL redir_flush: got fl=%b en=%b addr=%h, want 1 0 10", bif.flush_d_o, bif.en_f_o, bif.imem_addr_o);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        n_vec++;
        if ({bif.flush_d_o, bif.imem_req_o, bif.en_f_o, bif.imem_addr_o} !== {3'b010, 32'd16}) begin
            n_err++;
            $display("FAIL drain_wait: got fl=%b req=%b en=%b addr=%h, want 0 1 0 10",
                     bif.flush_d_o, bif.imem_req_o, bif.en_f_o, bif.imem_addr_o);
        end
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        n_vec++;
        if ({bif.imem_req_o, bif.en_f_o, bif.imem_addr_o} !== {2'b10, 32'd16}) begin
            n_err++;
            $display("FAIL drain_discard: got req=%b en=%b addr=%h, want 1 0 10", bif.imem_req_o, bif.en_f_o, bif.imem_addr_o);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({bif.en_f_o, bif.imem_addr_o, bif.pc_f_o, bif.fetch_cnt_o} !== {1'b1, 32'h100, 32'h100, 32'd4}) begin
            n_err++;
            $display("FAIL redir_target: got en=%b addr=%h pc=%h cnt=%0d, want 1 100 100 4",
                     bif.en_f_o, bif.imem_addr_o, bif.pc_f_o, bif.fetch_cnt_o);
        end
        tick();
    endtask

    task automatic test_double_redirect;
        drive(1'b0, 1'b0, 1'b1, 32'h200);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h300);
        @(negedge clk);
        n_vec++;
        if ({bif.flush_d_o, bif.imem_req_o, bif.en_f_o, bif.imem_addr_o} !== {3'b110, 32'h104}) begin
            n_err++;
            $display("FAIL dbl_second: got fl=%b req=%b en=%b addr=%h, want 1 1 0 104",
                     bif.flush_d_o, bif.imem_req_o, bif.en_f_o, bif.imem_addr_o);
        end
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        @(negedge clk);
        n_vec++;
        if ({bif.en_f_o, bif.imem_addr_o, bif.pc_f_o} !== {1'b1, 32'h300, 32'h300}) begin
            n_err++;
            $display("FAIL dbl_target: got en=%b addr=%h pc=%h, want 1 300 300", bif.en_f_o, bif.imem_addr_o, bif.pc_f_o);
        end
        tick();
    endtask

    task automatic test_hold_redirect;
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h400);
        @(negedge clk);
        n_vec++;
        if ({bif.flush_d_o, bif.en_f_o, bif.imem_req_o} !== 3'b100) begin
            n_err++;
            $display("FAIL hold_redir: got fl=%b en=%b req=%b, want 1 0 0", bif.flush_d_o, bif.en_f_o, bif.imem_req_o);
        end
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        n_vec++;
        if ({bif.imem_req_o, bif.en_f_o, bif.flush_d_o, bif.imem_addr_o, bif.pc_f_o} !== {3'b110, 32'h400, 32'h400}) begin
            n_err++;
            $display("FAIL hold_target: got req=%b en=%b fl=%b addr=%h pc=%h, want 1 1 0 400 400",
                     bif.imem_req_o, bif.en_f_o, bif.flush_d_o, bif.imem_addr_o, bif.pc_f_o);
        end
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h502);
        @(negedge clk);
        n_vec++;
        if ({bif.flush_d_o, bif.en_f_o} !== 2'b10) begin
            n_err++;
            $display("FAIL zw_redir: got fl=%b en=%b, want 1 0", bif.flush_d_o, bif.en_f_o);
        end
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        n_vec++;
        if ({bif.en_f_o, bif.flush_d_o, bif.imem_addr_o} !== {2'b10, 32'h500}) begin
            n_err++;
            $display("FAIL zw_target: got en=%b fl=%b addr=%h, want 1 0 500", bif.en_f_o, bif.flush_d_o, bif.imem_addr_o);
        end
        tick();
    endtask

    task automatic test_wrap;
        bif2.imem_ack_i = 1'b1;
        rst2 = 1'b0;
        tick();
        @(negedge clk);
        n_vec++;
        if ({bif2.en_f_o, bif2.imem_addr_o, bif2.pc_f_o} !== {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC}) begin
            n_err++;
            $display("FAIL wrap_first: got en=%b addr=%h pc=%h, want 1 fffffffc", bif2.en_f_o, bif2.imem_addr_o, bif2.pc_f_o);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({bif2.en_f_o, bif2.imem_addr_o, bif2.pc_f_o, bif2.instr_f_o} !== {1'b1, 32'd0, 32'd0, 32'hFFFF_FFFF}) begin
            n_err++;
            $display("FAIL wrap_zero: got en=%b addr=%h pc=%h ins=%h, want 1 0 0 ffffffff",
                     bif2.en_f_o, bif2.imem_addr_o, bif2.pc_f_o, bif2.instr_f_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_hold;
        do_reset();
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        @(negedge clk);
        n_vec++;
        if ({bif.imem_req_o, bif.pc_f_o} !== {1'b0, 32'd4}) begin
            n_err++;
            $display("FAIL pre_reset_hold: got req=%b pc=%h, want 0 4", bif.imem_req_o, bif.pc_f_o);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bif.imem_req_o, bif.en_f_o, bif.flush_d_o, bif.imem_addr_o, bif.pc_f_o, bif.instr_f_o, bif.fetch_cnt_o}
            !== {3'b000, 32'd0, 32'd0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL async_reset: got req=%b en=%b fl=%b addr=%h pc=%h ins=%h cnt=%0d, want all 0",
                     bif.imem_req_o, bif.en_f_o, bif.flush_d_o, bif.imem_addr_o, bif.pc_f_o, bif.instr_f_o, bif.fetch_cnt_o);
        end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst2 = 1'b1;
        bif2.imem_ack_i    = 1'b0;
        bif2.stall_d_i     = 1'b0;
        bif2.redirect_i    = 1'b0;
        bif2.redirect_pc_i = 32'd0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drain();
        test_double_redirect();
        test_hold_redirect();
        test_wrap();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
